// File: rtl/i2c_host_master.sv
// Byte-level I2C bus master: one command moves one byte, optionally framed by
// a START/repeated START before it and a STOP after its ACK bit.
module i2c_host_master #(
   parameter int CLK_DIV = 8
) (
   input  logic       clk,
   input  logic       n_rst,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic       cmd_start,
   input  logic       cmd_stop,
   input  logic       cmd_read,
   input  logic       cmd_nack,
   input  logic [7:0] tx_byte,
   output logic       rsp_valid,
   output logic [7:0] rx_byte,
   output logic       ack_received,
   output logic       busy,
   output logic       scl,
   output logic       sda_out,
   input  logic       sda_in
);

   typedef enum logic [2:0] {IDLE, HOLD, START, BIT, ACK, STOP} state_t;

   localparam logic [7:0] Q_LAST = 8'(CLK_DIV - 1);

   state_t     state;
   logic [7:0] q_cnt;
   logic [1:0] quarter;
   logic [2:0] bit_cnt;
   logic [7:0] shreg;
   logic       lat_stop;
   logic       lat_read;
   logic       lat_nack;
   logic       q_end;

   // Last cycle of the current quarter period
   always_comb begin
      q_end = (q_cnt == Q_LAST);
   end

   // Bus sequencer. Outputs are set on the edge that enters each quarter, so
   // they hold for the whole quarter. In IDLE/HOLD a low cmd_ready means an
   // operation has just finished and its response is reported this edge.
   always_ff @(posedge clk) begin
      if (!n_rst) begin
         state        <= IDLE;
         q_cnt        <= 8'd0;
         quarter      <= 2'd0;
         bit_cnt      <= 3'd0;
         shreg        <= 8'd0;
         lat_stop     <= 1'b0;
         lat_read     <= 1'b0;
         lat_nack     <= 1'b0;
         cmd_ready    <= 1'b1;
         rsp_valid    <= 1'b0;
         rx_byte      <= 8'd0;
         ack_received <= 1'b0;
         busy         <= 1'b0;
         scl          <= 1'b1;
         sda_out      <= 1'b1;
      end else begin
         rsp_valid <= 1'b0;
         case (state)
            IDLE, HOLD: begin
               if (!cmd_ready) begin
                  cmd_ready <= 1'b1;
                  rsp_valid <= 1'b1;
                  busy      <= (state == HOLD);
                  if (lat_read) begin
                     rx_byte <= shreg;
                  end
               end else if (cmd_valid) begin
                  cmd_ready <= 1'b0;
                  busy      <= 1'b1;
                  lat_stop  <= cmd_stop;
                  lat_read  <= cmd_read;
                  lat_nack  <= cmd_nack;
                  q_cnt     <= 8'd0;
                  quarter   <= 2'd0;
                  shreg     <= cmd_read ? 8'h00 : tx_byte;
                  if ((state == IDLE) || cmd_start) begin
                     state   <= START;
                     scl     <= (state == IDLE);
                     sda_out <= 1'b1;
                  end else begin
                     state   <= BIT;
                     bit_cnt <= 3'd7;
                     scl     <= 1'b0;
                     sda_out <= cmd_read ? 1'b1 : tx_byte[7];
                  end
               end
            end
            default: begin
               q_cnt <= q_end ? 8'd0 : q_cnt + 8'd1;
               if (q_end) begin
                  quarter <= quarter + 2'd1;
                  case (state)
                     START: begin
                        case (quarter)
                           2'd0: begin
                              scl     <= 1'b1;
                              sda_out <= 1'b1;
                           end
                           2'd1: sda_out <= 1'b0;
                           2'd3: begin
                              state   <= BIT;
                              bit_cnt <= 3'd7;
                              scl     <= 1'b0;
                              sda_out <= lat_read ? 1'b1 : shreg[7];
                           end
                           default: ;
                        endcase
                     end
                     BIT: begin
                        case (quarter)
                           2'd1: scl <= 1'b1;
                           2'd2: begin
                              if (lat_read) begin
                                 shreg <= {shreg[6:0], sda_in};
                              end
                           end
                           2'd3: begin
                              scl <= 1'b0;
                              if (bit_cnt == 3'd0) begin
                                 state   <= ACK;
                                 sda_out <= lat_read ? lat_nack : 1'b1;
                              end else begin
                                 bit_cnt <= bit_cnt - 3'd1;
                                 if (lat_read) begin
                                    sda_out <= 1'b1;
                                 end else begin
                                    shreg   <= {shreg[6:0], 1'b0};
                                    sda_out <= shreg[6];
                                 end
                              end
                           end
                           default: ;
                        endcase
                     end
                     ACK: begin
                        case (quarter)
                           2'd1: scl <= 1'b1;
                           2'd2: begin
                              if (!lat_read) begin
                                 ack_received <= ~sda_in;
                              end
                           end
                           2'd3: begin
                              scl <= 1'b0;
                              if (lat_stop) begin
                                 state   <= STOP;
                                 sda_out <= 1'b0;
                              end else begin
                                 state <= HOLD;
                              end
                           end
                           default: ;
                        endcase
                     end
                     STOP: begin
                        case (quarter)
                           2'd0: scl <= 1'b1;
                           2'd1: sda_out <= 1'b1;
                           2'd3: state <= IDLE;
                           default: ;
                        endcase
                     end
                     default: state <= IDLE;
                  endcase
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_i2c_host_master.sv
// Bench for i2c_host_master: a behavioural slave/bus monitor sits on the wire,
// commands are issued one at a time and checked against expectations derived
// from the bus rules (bit order, framing, latency in quarter periods).
module tb_i2c_host_master;

   localparam int D = 4;

   logic       clk = 1'b0;
   logic       n_rst = 1'b0;
   logic       cmd_valid = 1'b0;
   logic       cmd_ready;
   logic       cmd_start = 1'b0;
   logic       cmd_stop = 1'b0;
   logic       cmd_read = 1'b0;
   logic       cmd_nack = 1'b0;
   logic [7:0] tx_byte = 8'h00;
   logic       rsp_valid;
   logic [7:0] rx_byte;
   logic       ack_received;
   logic       busy;
   logic       scl;
   logic       sda_out;
   logic       slave_drive = 1'b1;
   logic       sda_line;

   int total = 0;
   int bad = 0;
   int cyc = 0;

   // Bench-side view of who owns the bus and what the slave will do
   logic       model_owned = 1'b0;
   logic       started = 1'b0;
   logic       slv_read = 1'b0;
   logic [7:0] slv_byte = 8'h00;
   logic       slv_ack = 1'b0;
   int         op_id = 0;

   // Monitor results for the current operation
   int         mon_id = 0;
   int         falls = 0;
   int         nbits = 0;
   int         starts = 0;
   int         stops = 0;
   int         mon_idx = 0;
   logic [8:0] bits = '1;
   logic       p_scl = 1'b1;
   logic       p_sda = 1'b1;

   assign sda_line = sda_out & slave_drive;

   i2c_host_master #(.CLK_DIV(D)) dut (
      .clk(clk), .n_rst(n_rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_start(cmd_start), .cmd_stop(cmd_stop),
      .cmd_read(cmd_read), .cmd_nack(cmd_nack), .tx_byte(tx_byte),
      .rsp_valid(rsp_valid), .rx_byte(rx_byte), .ack_received(ack_received),
      .busy(busy), .scl(scl), .sda_out(sda_out), .sda_in(sda_line)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Slave and bus monitor: counts SCL falls to locate the data bit, records
   // the line level at each SCL rise, detects START/STOP conditions and drives
   // the slave's data or ACK while SCL is low.
   always @(negedge clk) begin
      if (mon_id != op_id) begin
         mon_id = op_id;
         falls = 0;
         nbits = 0;
         starts = 0;
         stops = 0;
         bits = '1;
      end else begin
         if (p_scl && !scl) falls++;
         if (!p_scl && scl) begin
            mon_idx = falls - (started ? 1 : 0);
            if (mon_idx >= 0 && mon_idx <= 8) begin
               bits[8 - mon_idx] = sda_line;
               nbits++;
            end
         end
         if (p_scl && scl && p_sda && !sda_line) starts++;
         if (p_scl && scl && !p_sda && sda_line) stops++;
      end
      p_scl = scl;
      p_sda = sda_line;
      mon_idx = falls - (started ? 1 : 0);
      if (mon_idx >= 0 && mon_idx <= 7)
         slave_drive = slv_read ? slv_byte[7 - mon_idx] : 1'b1;
      else if (mon_idx == 8)
         slave_drive = slv_read ? 1'b1 : ~slv_ack;
      else
         slave_drive = 1'b1;
   end

   // Bits seen on the wire during SCL high: data MSB first then the 9th bit
   function automatic logic [8:0] exp_bits(input logic rd, input logic [7:0] tx,
                                           input logic [7:0] sb, input logic sack,
                                           input logic nk);
      return rd ? {sb, nk} : {tx, ~sack};
   endfunction

   // Cycles from accept edge to rsp_valid: 36 quarters per byte+ACK, 4 each
   // for START and STOP, plus one reporting cycle
   function automatic int exp_lat(input logic st_runs, input logic sp);
      return (36 + (st_runs ? 4 : 0) + (sp ? 4 : 0)) * D + 1;
   endfunction

   // Issue one command, optionally poke a second command mid-byte, and wait
   // (bounded) for the response
   task automatic do_cmd(input logic st, input logic sp, input logic rd,
                         input logic nk, input logic [7:0] tx,
                         input logic [7:0] sb, input logic sack,
                         input int glitch_at, output int acc_cyc, output int lat);
      int waited;
      waited = 0;
      while (!cmd_ready && waited < 2000) begin
         @(posedge clk); #1;
         waited++;
      end
      slv_read = rd;
      slv_byte = sb;
      slv_ack = sack;
      started = !model_owned || st;
      cmd_valid = 1'b1;
      cmd_start = st;
      cmd_stop = sp;
      cmd_read = rd;
      cmd_nack = nk;
      tx_byte = tx;
      @(posedge clk); #1;
      acc_cyc = cyc;
      cmd_valid = 1'b0;
      op_id++;
      lat = -1;
      for (int k = 1; k <= 2000; k++) begin
         @(posedge clk); #1;
         if (k == glitch_at) begin
            cmd_valid = 1'b1;
            tx_byte = ~tx;
         end else if (k == glitch_at + 1) begin
            cmd_valid = 1'b0;
            tx_byte = tx;
         end
         if (rsp_valid) begin
            lat = cyc - acc_cyc;
            break;
         end
      end
      model_owned = !sp;
   endtask

   task automatic test_reset();
      n_rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      total++; if (scl !== 1'b1) begin bad++; $display("[TB] FAIL reset_scl got=%b want=1", scl); end
      total++; if (sda_out !== 1'b1) begin bad++; $display("[TB] FAIL reset_sda got=%b want=1", sda_out); end
      total++; if (cmd_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_ready got=%b want=1", cmd_ready); end
      total++; if (rsp_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_rsp got=%b want=0", rsp_valid); end
      total++; if (rx_byte !== 8'h00) begin bad++; $display("[TB] FAIL reset_rx got=%h want=00", rx_byte); end
      total++; if (ack_received !== 1'b0) begin bad++; $display("[TB] FAIL reset_ack got=%b want=0", ack_received); end
      total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy got=%b want=0", busy); end
      n_rst = 1'b1;
      model_owned = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_write_start_stop();
      int acc, lat;
      do_cmd(1, 1, 0, 0, 8'hA5, 8'h00, 1, 0, acc, lat);
      total++; if (lat !== exp_lat(1, 1)) begin bad++; $display("[TB] FAIL wr_a5_latency got=%0d want=%0d", lat, exp_lat(1, 1)); end
      total++; if (bits !== exp_bits(0, 8'hA5, 8'h00, 1, 0)) begin bad++; $display("[TB] FAIL wr_a5_bits got=%h want=%h", bits, exp_bits(0, 8'hA5, 8'h00, 1, 0)); end
      total++; if (ack_received !== 1'b1) begin bad++; $display("[TB] FAIL wr_a5_ack got=%b want=1", ack_received); end
      total++; if ({scl, sda_out, busy} !== 3'b110) begin bad++; $display("[TB] FAIL wr_a5_bus got=%b want=110", {scl, sda_out, busy}); end
      total++; if ({starts, stops} !== {32'd1, 32'd1}) begin bad++; $display("[TB] FAIL wr_a5_framing got=%0d/%0d want=1/1", starts, stops); end
   endtask

   task automatic test_write_nack_hold();
      int acc, lat;
      do_cmd(1, 0, 0, 0, 8'h3F, 8'h00, 0, 0, acc, lat);
      total++; if (lat !== exp_lat(1, 0)) begin bad++; $display("[TB] FAIL wr_3f_latency got=%0d want=%0d", lat, exp_lat(1, 0)); end
      total++; if (bits !== exp_bits(0, 8'h3F, 8'h00, 0, 0)) begin bad++; $display("[TB] FAIL wr_3f_bits got=%h want=%h", bits, exp_bits(0, 8'h3F, 8'h00, 0, 0)); end
      total++; if (ack_received !== 1'b0) begin bad++; $display("[TB] FAIL wr_3f_ack got=%b want=0", ack_received); end
      total++; if ({scl, busy, cmd_ready} !== 3'b011) begin bad++; $display("[TB] FAIL wr_3f_hold got=%b want=011", {scl, busy, cmd_ready}); end
   endtask

   task automatic test_read_repeated_start();
      int acc, lat;
      do_cmd(1, 1, 1, 1, 8'h00, 8'h3C, 0, 0, acc, lat);
      total++; if (lat !== exp_lat(1, 1)) begin bad++; $display("[TB] FAIL rd_3c_latency got=%0d want=%0d", lat, exp_lat(1, 1)); end
      total++; if (rx_byte !== 8'h3C) begin bad++; $display("[TB] FAIL rd_3c_data got=%h want=3c", rx_byte); end
      total++; if (bits !== exp_bits(1, 8'h00, 8'h3C, 0, 1)) begin bad++; $display("[TB] FAIL rd_3c_bits got=%h want=%h", bits, exp_bits(1, 8'h00, 8'h3C, 0, 1)); end
      total++; if ({starts, stops} !== {32'd1, 32'd1}) begin bad++; $display("[TB] FAIL rd_3c_framing got=%0d/%0d want=1/1", starts, stops); end
      total++; if ({scl, sda_out, busy} !== 3'b110) begin bad++; $display("[TB] FAIL rd_3c_bus got=%b want=110", {scl, sda_out, busy}); end
   endtask

   task automatic test_read_from_hold();
      int acc, lat;
      do_cmd(1, 0, 0, 0, 8'h55, 8'h00, 1, 0, acc, lat);
      do_cmd(0, 0, 1, 0, 8'h00, 8'hFF, 0, 0, acc, lat);
      total++; if (lat !== exp_lat(0, 0)) begin bad++; $display("[TB] FAIL rd_ff_latency got=%0d want=%0d", lat, exp_lat(0, 0)); end
      total++; if (rx_byte !== 8'hFF) begin bad++; $display("[TB] FAIL rd_ff_data got=%h want=ff", rx_byte); end
      total++; if (bits !== exp_bits(1, 8'h00, 8'hFF, 0, 0)) begin bad++; $display("[TB] FAIL rd_ff_bits got=%h want=%h", bits, exp_bits(1, 8'h00, 8'hFF, 0, 0)); end
      total++; if ({starts, stops} !== {32'd0, 32'd0}) begin bad++; $display("[TB] FAIL rd_ff_framing got=%0d/%0d want=0/0", starts, stops); end
      total++; if ({scl, busy} !== 2'b01) begin bad++; $display("[TB] FAIL rd_ff_hold got=%b want=01", {scl, busy}); end
   endtask

   task automatic test_ignore_busy_cmd();
      int acc, lat, extra;
      do_cmd(1, 1, 0, 0, 8'h5A, 8'h00, 1, 60, acc, lat);
      total++; if (lat !== exp_lat(1, 1)) begin bad++; $display("[TB] FAIL ign_latency got=%0d want=%0d", lat, exp_lat(1, 1)); end
      total++; if (bits !== exp_bits(0, 8'h5A, 8'h00, 1, 0)) begin bad++; $display("[TB] FAIL ign_bits got=%h want=%h", bits, exp_bits(0, 8'h5A, 8'h00, 1, 0)); end
      extra = 0;
      for (int k = 0; k < 200; k++) begin
         @(posedge clk); #1;
         if (rsp_valid) extra++;
      end
      total++; if (extra !== 0) begin bad++; $display("[TB] FAIL ign_extra_rsp got=%0d want=0", extra); end
   endtask

   task automatic test_back_to_back();
      int acc1, lat1, acc2, lat2;
      logic [7:0] sb;
      sb = 8'($urandom);
      do_cmd(1, 0, 0, 0, 8'($urandom), 8'h00, 1, 0, acc1, lat1);
      do_cmd(0, 1, 1, 1, 8'h00, sb, 0, 0, acc2, lat2);
      total++; if (acc2 - (acc1 + lat1) !== 1) begin bad++; $display("[TB] FAIL b2b_gap got=%0d want=1", acc2 - (acc1 + lat1)); end
      total++; if (lat2 !== exp_lat(0, 1)) begin bad++; $display("[TB] FAIL b2b_latency got=%0d want=%0d", lat2, exp_lat(0, 1)); end
      total++; if (rx_byte !== sb) begin bad++; $display("[TB] FAIL b2b_data got=%h want=%h", rx_byte, sb); end
   endtask

   task automatic test_random();
      int acc, lat;
      logic st, sp, rd, nk, sack, st_runs;
      logic [7:0] tx, sb;
      for (int n = 0; n < 20; n++) begin
         st = 1'($urandom); sp = 1'($urandom); rd = 1'($urandom);
         nk = 1'($urandom); sack = 1'($urandom);
         tx = 8'($urandom); sb = 8'($urandom);
         st_runs = !model_owned || st;
         do_cmd(st, sp, rd, nk, tx, sb, sack, 0, acc, lat);
         total++; if (lat !== exp_lat(st_runs, sp)) begin bad++; $display("[TB] FAIL rnd%0d_latency got=%0d want=%0d", n, lat, exp_lat(st_runs, sp)); end
         total++; if (bits !== exp_bits(rd, tx, sb, sack, nk) || nbits !== 9) begin bad++; $display("[TB] FAIL rnd%0d_bits got=%h/%0d want=%h/9", n, bits, nbits, exp_bits(rd, tx, sb, sack, nk)); end
         total++;
         if (rd ? (rx_byte !== sb) : (ack_received !== sack)) begin
            bad++; $display("[TB] FAIL rnd%0d_result got=%h/%b want=%h/%b", n, rx_byte, ack_received, sb, sack);
         end
         total++; if ({scl, busy} !== (sp ? 2'b10 : 2'b01)) begin bad++; $display("[TB] FAIL rnd%0d_bus got=%b want=%b", n, {scl, busy}, sp ? 2'b10 : 2'b01); end
         total++; if (starts !== (st_runs ? 1 : 0) || stops !== (sp ? 1 : 0)) begin bad++; $display("[TB] FAIL rnd%0d_framing got=%0d/%0d want=%0d/%0d", n, starts, stops, st_runs, sp); end
      end
   endtask

   task automatic test_reset_mid_op();
      int seen;
      while (!cmd_ready) begin @(posedge clk); #1; end
      started = 1'b1;
      slv_read = 1'b0;
      slv_ack = 1'b1;
      cmd_valid = 1'b1; cmd_start = 1'b1; cmd_stop = 1'b1; cmd_read = 1'b0;
      tx_byte = 8'h81;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      op_id++;
      repeat (5 * D + 1) @(posedge clk);
      #1;
      total++; if (scl !== 1'b0) begin bad++; $display("[TB] FAIL rst_mid_pre_scl got=%b want=0", scl); end
      n_rst = 1'b0;
      @(posedge clk); #1;
      total++; if ({scl, sda_out, cmd_ready, busy, rsp_valid} !== 5'b11100) begin bad++; $display("[TB] FAIL rst_mid_outputs got=%b want=11100", {scl, sda_out, cmd_ready, busy, rsp_valid}); end
      @(posedge clk); #1;
      n_rst = 1'b1;
      model_owned = 1'b0;
      seen = 0;
      for (int k = 0; k < 300; k++) begin
         @(posedge clk); #1;
         if (rsp_valid) seen++;
      end
      total++; if (seen !== 0) begin bad++; $display("[TB] FAIL rst_mid_stale_rsp got=%0d want=0", seen); end
   endtask

   initial begin
      test_reset();
      test_write_start_stop();
      test_write_nack_hold();
      test_read_repeated_start();
      test_read_from_hold();
      test_ignore_busy_cmd();
      test_back_to_back();
      test_random();
      test_reset_mid_op();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Global time limit so a stuck run still ends
   initial begin
      #3000000;
      $display("[TB] FAIL watchdog expired total=%0d bad=%0d", total, bad);
      $fatal(1, "[TB] watchdog");
   end

endmodule
